// File: rtl/eth_reset_sequencer.sv
// eth_reset_sequencer: synchronizes the board reset, then releases the
// ethernet stage resets in index order, waiting (with timeout) for each
// stage's acknowledge. A sampled-high soft_reset_i re-runs the sequence.
module eth_reset_sequencer #(
  parameter int num_stages_p  = 3,
  parameter int hold_cycles_p = 16,
  parameter int stage_gap_p   = 8,
  parameter int ack_timeout_p = 1024
) (
  input  logic                    clk_i,
  input  logic                    async_reset_i,
  input  logic                    soft_reset_i,
  input  logic [num_stages_p-1:0] stage_ack_i,
  output logic [num_stages_p-1:0] stage_reset_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [num_stages_p-1:0] timeout_o
);

  localparam int max_hg_lp  = (hold_cycles_p > stage_gap_p) ? hold_cycles_p : stage_gap_p;
  localparam int max_cnt_lp = (max_hg_lp > ack_timeout_p) ? max_hg_lp : ack_timeout_p;
  localparam int cnt_w_lp   = $clog2(max_cnt_lp + 1);
  localparam int idx_w_lp   = (num_stages_p > 1) ? $clog2(num_stages_p) : 1;

  // Terminal counts; each phase stops at its terminal value, so no wrap.
  localparam logic [cnt_w_lp-1:0] hold_last_lp = cnt_w_lp'(hold_cycles_p - 1);
  localparam logic [cnt_w_lp-1:0] gap_last_lp  = cnt_w_lp'((stage_gap_p > 0) ? stage_gap_p - 1 : 0);
  localparam logic [cnt_w_lp-1:0] ack_last_lp  = cnt_w_lp'(ack_timeout_p - 1);
  localparam logic [idx_w_lp-1:0] idx_last_lp  = idx_w_lp'(num_stages_p - 1);

  localparam logic [1:0] st_hold     = 2'd0;
  localparam logic [1:0] st_wait_ack = 2'd1;
  localparam logic [1:0] st_gap      = 2'd2;
  localparam logic [1:0] st_done     = 2'd3;

  logic [1:0]              sync_q, sync_d;
  logic                    rst_sync;
  logic [1:0]              state_q, state_d;
  logic [cnt_w_lp-1:0]     cnt_q, cnt_d;
  logic [idx_w_lp-1:0]     idx_q, idx_d, idx_nx;
  logic [num_stages_p-1:0] stage_reset_q, stage_reset_d;
  logic [num_stages_p-1:0] timeout_q, timeout_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    advance;

  // Shift a 0 through the synchronizer; async set re-arms it at once.
  always_comb begin
    sync_d = {sync_q[0], 1'b0};
  end

  // Reset synchronizer: asserts asynchronously, releases on the 2nd edge.
  always_ff @(posedge clk_i or posedge async_reset_i) begin
    if (async_reset_i) sync_q <= 2'b11;
    else               sync_q <= sync_d;
  end

  assign rst_sync = sync_q[1];
  assign idx_nx   = idx_q + 1'b1;

  // Sequencer next-state: soft reset overrides everything, else walk stages.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    stage_reset_d = stage_reset_q;
    timeout_d     = timeout_q;
    busy_d        = busy_q;
    done_d        = done_q;
    advance       = 1'b0;

    if (soft_reset_i) begin
      state_d       = st_hold;
      cnt_d         = '0;
      idx_d         = '0;
      stage_reset_d = '1;
      timeout_d     = '0;
      busy_d        = 1'b1;
      done_d        = 1'b0;
    end else begin
      case (state_q)
        st_hold: begin
          if (cnt_q == hold_last_lp) begin
            stage_reset_d[0] = 1'b0;
            state_d          = st_wait_ack;
            idx_d            = '0;
            cnt_d            = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        st_wait_ack: begin
          // A late stage is flagged but does not stall the rest of the chain.
          if (stage_ack_i[idx_q]) begin
            advance = 1'b1;
          end else if (cnt_q == ack_last_lp) begin
            timeout_d[idx_q] = 1'b1;
            advance          = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          if (advance) begin
            cnt_d = '0;
            if (idx_q == idx_last_lp) begin
              state_d = st_done;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else if (stage_gap_p == 0) begin
              // No gap: next stage releases on the same edge the ack is taken.
              stage_reset_d[idx_nx] = 1'b0;
              idx_d                 = idx_nx;
              state_d               = st_wait_ack;
            end else begin
              state_d = st_gap;
            end
          end
        end
        st_gap: begin
          if (cnt_q == gap_last_lp) begin
            stage_reset_d[idx_nx] = 1'b0;
            idx_d                 = idx_nx;
            cnt_d                 = '0;
            state_d               = st_wait_ack;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          // Done: acknowledges are ignored until a soft or board reset.
        end
      endcase
    end
  end

  // Sequencer state: async board reset, then held while the synchronizer is high.
  always_ff @(posedge clk_i or posedge async_reset_i) begin
    if (async_reset_i) begin
      state_q       <= st_hold;
      cnt_q         <= '0;
      idx_q         <= '0;
      stage_reset_q <= '1;
      timeout_q     <= '0;
      busy_q        <= 1'b1;
      done_q        <= 1'b0;
    end else if (rst_sync) begin
      state_q       <= st_hold;
      cnt_q         <= '0;
      idx_q         <= '0;
      stage_reset_q <= '1;
      timeout_q     <= '0;
      busy_q        <= 1'b1;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      stage_reset_q <= stage_reset_d;
      timeout_q     <= timeout_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign stage_reset_o = stage_reset_q;
  assign timeout_o     = timeout_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_eth_reset_sequencer.sv
// tb_eth_reset_sequencer: two instances (gap 8 with looped-back acks, gap 0
// with acks tied high) compared every cycle against a release-schedule model.
module tb_eth_reset_sequencer;
  localparam int NS = 3, HC = 16, GAP = 8, TO = 64;

  logic          clk_i = 1'b0;
  logic          async_reset_i = 1'b0;
  logic          soft_reset_i = 1'b0;
  logic [NS-1:0] ack_a = '0, ack_b = '1;
  logic [NS-1:0] rst_a, rst_b, to_a, to_b;
  logic          busy_a, busy_b, done_a, done_b;

  always #5 clk_i = ~clk_i;

  eth_reset_sequencer #(.num_stages_p(NS), .hold_cycles_p(HC), .stage_gap_p(GAP), .ack_timeout_p(TO)) u_dut (
    .clk_i(clk_i), .async_reset_i(async_reset_i), .soft_reset_i(soft_reset_i),
    .stage_ack_i(ack_a), .stage_reset_o(rst_a), .busy_o(busy_a), .done_o(done_a), .timeout_o(to_a));

  eth_reset_sequencer #(.num_stages_p(NS), .hold_cycles_p(HC), .stage_gap_p(0), .ack_timeout_p(TO)) u_gap0 (
    .clk_i(clk_i), .async_reset_i(async_reset_i), .soft_reset_i(soft_reset_i),
    .stage_ack_i(ack_b), .stage_reset_o(rst_b), .busy_o(busy_b), .done_o(done_b), .timeout_o(to_b));

  int checks = 0, errors = 0, cyc = 0;

  // Reference model: release count plus absolute edge numbers of the next event.
  int            m_gap[2] = '{GAP, 0};
  int            m_rel[2], m_rel_at[2], m_wait_start[2];
  bit            m_done[2];
  logic [NS-1:0] m_to[2];
  int            m_sync_left = 2;
  int            last_rst_edge = 0;

  // Ack stimulus for instance a
  int            mode[NS], dly[NS];
  logic [NS-1:0] hist[4];
  int            rel_edge_a[NS], rel_edge_b[NS], done_edge_a, done_edge_b;
  logic [NS-1:0] prev_a = '1, prev_b = '1;
  logic          prev_da = 1'b0, prev_db = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic m_reset(input int k, input int c);
    m_rel[k] = 0; m_done[k] = 0; m_to[k] = '0;
    m_rel_at[k] = c + HC; m_wait_start[k] = -1;
  endtask

  task automatic m_release(input int k, input int c);
    m_rel[k]++; m_wait_start[k] = c; m_rel_at[k] = -1;
  endtask

  task automatic m_step(input int k, input int c, input logic [NS-1:0] ack);
    int s; bit fin;
    fin = 0;
    if (m_done[k]) return;
    if (m_wait_start[k] < 0) begin
      if (c == m_rel_at[k]) m_release(k, c);
    end else begin
      s = m_rel[k] - 1;
      if (ack[s]) fin = 1;
      else if (c - m_wait_start[k] == TO) begin m_to[k][s] = 1'b1; fin = 1; end
      if (fin) begin
        m_wait_start[k] = -1;
        if (m_rel[k] == NS) m_done[k] = 1;
        else if (m_gap[k] == 0) m_release(k, c);
        else m_rel_at[k] = c + m_gap[k];
      end
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      logic [NS-1:0] r, t, e, n;
      logic b, d;
      r = (k == 0) ? rst_a : rst_b;
      t = (k == 0) ? to_a : to_b;
      b = (k == 0) ? busy_a : busy_b;
      d = (k == 0) ? done_a : done_b;
      for (int i = 0; i < NS; i++) e[i] = (i >= m_rel[k]);
      n = ~r;
      chk($sformatf("stage_reset%0d", k), 32'(r), 32'(e));
      chk($sformatf("busy%0d", k), 32'(b), 32'(!m_done[k]));
      chk($sformatf("done%0d", k), 32'(d), 32'(m_done[k]));
      chk($sformatf("timeout%0d", k), 32'(t), 32'(m_to[k]));
      chk($sformatf("order%0d", k), 32'((n & (n + 1'b1)) == '0), 32'd1);
      chk($sformatf("busy_and_done%0d", k), 32'(b & d), 32'd0);
    end
  endtask

  task automatic tick();
    logic [NS-1:0] ab;
    bit sft, arst;
    ab = ack_a; sft = soft_reset_i; arst = async_reset_i;
    @(posedge clk_i);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (arst || m_sync_left > 0 || sft) begin
        m_reset(k, cyc);
        last_rst_edge = cyc;
      end else begin
        m_step(k, cyc, (k == 0) ? ab : '1);
      end
    end
    if (arst) m_sync_left = 2;
    else if (m_sync_left > 0) m_sync_left--;
    #1;
    check_outputs();
    for (int i = 0; i < NS; i++) begin
      if (prev_a[i] && !rst_a[i]) rel_edge_a[i] = cyc;
      if (prev_b[i] && !rst_b[i]) rel_edge_b[i] = cyc;
    end
    if (!prev_da && done_a) done_edge_a = cyc;
    if (!prev_db && done_b) done_edge_b = cyc;
    prev_a = rst_a; prev_b = rst_b; prev_da = done_a; prev_db = done_b;
    for (int d = 3; d > 0; d--) hist[d] = hist[d-1];
    hist[0] = ~rst_a;
    for (int i = 0; i < NS; i++) begin
      case (mode[i])
        0:       ack_a[i] = hist[dly[i]-1][i];
        1:       ack_a[i] = 1'b0;
        2:       ack_a[i] = 1'b1;
        default: ack_a[i] = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic soft_pulse();
    soft_reset_i = 1'b1;
    tick();
    soft_reset_i = 1'b0;
  endtask

  // Pulse the board reset between edges and check the asynchronous response.
  task automatic async_pulse();
    #2 async_reset_i = 1'b1;
    for (int k = 0; k < 2; k++) m_reset(k, cyc);
    m_sync_left = 2;
    #1;
    chk("async_rst_a", 32'(rst_a), 32'h7);
    chk("async_rst_b", 32'(rst_b), 32'h7);
    check_outputs();
    #1 async_reset_i = 1'b0;
  endtask

  task automatic check_timing(input string tag, input int e0, input int e1, input int e2, input int ed);
    chk({tag, "_rel0"}, 32'(rel_edge_a[0] - last_rst_edge), 32'(e0));
    chk({tag, "_rel1"}, 32'(rel_edge_a[1] - last_rst_edge), 32'(e1));
    chk({tag, "_rel2"}, 32'(rel_edge_a[2] - last_rst_edge), 32'(e2));
    chk({tag, "_done"}, 32'(done_edge_a - last_rst_edge), 32'(ed));
    chk({tag, "_g0_rel0"}, 32'(rel_edge_b[0] - last_rst_edge), 32'(HC));
    chk({tag, "_g0_rel1"}, 32'(rel_edge_b[1] - last_rst_edge), 32'(HC + 1));
    chk({tag, "_g0_rel2"}, 32'(rel_edge_b[2] - last_rst_edge), 32'(HC + 2));
    chk({tag, "_g0_done"}, 32'(done_edge_b - last_rst_edge), 32'(HC + 3));
  endtask

  initial begin
    int soft_left;
    for (int d = 0; d < 4; d++) hist[d] = '0;
    for (int i = 0; i < NS; i++) begin mode[i] = 0; dly[i] = 3; end
    for (int k = 0; k < 2; k++) m_reset(k, 0);

    // Power-on
    #1 async_reset_i = 1'b1;
    #1 check_outputs();
    ticks(2);
    async_reset_i = 1'b0;
    cyc = 0;
    ticks(60);
    check_timing("poweron", HC, HC + 3 + GAP, HC + 2 * (3 + GAP), HC + 3 * 3 + 2 * GAP);

    // Soft reset pulse while done
    soft_pulse();
    chk("soft_done_rst", 32'(rst_a), 32'h7);
    chk("soft_done_busy", 32'(busy_a), 32'd1);
    ticks(60);
    check_timing("soft", HC, HC + 3 + GAP, HC + 2 * (3 + GAP), HC + 3 * 3 + 2 * GAP);

    // Stage 1 never acknowledges
    mode[1] = 1;
    soft_pulse();
    ticks(120);
    check_timing("timeout", HC, HC + 3 + GAP, HC + 3 + GAP + TO + GAP, HC + 3 + GAP + TO + GAP + 3);
    chk("timeout_flag", 32'(to_a), 32'h2);
    mode[1] = 0;

    // Soft reset during the gap after stage 0
    soft_pulse();
    ticks(22);
    soft_reset_i = 1'b1;
    tick();
    chk("soft_gap_rst", 32'(rst_a), 32'h7);
    ticks(2);
    soft_reset_i = 1'b0;
    ticks(30);
    chk("soft_gap_rel0", 32'(rel_edge_a[0] - last_rst_edge), 32'(HC));

    // Board reset mid-wait
    soft_pulse();
    ticks(HC + 1);
    async_pulse();
    ticks(60);
    check_timing("async", HC, HC + 3 + GAP, HC + 2 * (3 + GAP), HC + 3 * 3 + 2 * GAP);

    // Randomized ack behaviour, soft and board resets
    soft_left = 0;
    for (int it = 0; it < 20; it++) begin
      int n;
      for (int i = 0; i < NS; i++) begin
        mode[i] = $urandom_range(0, 3);
        dly[i]  = $urandom_range(1, 3);
      end
      n = $urandom_range(150, 300);
      for (int c = 0; c < n; c++) begin
        if (soft_left == 0 && $urandom_range(0, 99) == 0) soft_left = $urandom_range(1, 3);
        soft_reset_i = (soft_left > 0);
        if (soft_left > 0) soft_left--;
        tick();
        if ($urandom_range(0, 299) == 0) async_pulse();
      end
    end
    soft_reset_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
